ccff_loader: RTL and testbench
==============================

# ccff_loader

Configuration-chain loader for the eFPGA fabric. Accepts the bitstream as a stream of fixed-width words over a valid/ready handshake and serializes it into `NUM_CHAINS` parallel configuration flip-flop chains. The chains are the `ccff_head`→`ccff_tail` scan paths threaded through the fabric's config cells and buffers. It sits between the bitstream source (SPI/JTAG bridge or testbench) and the fabric top. It sequences the chain shift enable, counts shifts to exactly `CHAIN_LEN`, and reports completion plus a parity signature of the bits shifted out of the tails.

## Interface
- `NUM_CHAINS`, 4, number of parallel config chains; must divide `WORD_W`.
- `CHAIN_LEN`, 1024, flip-flops per chain, which is the number of shifts per load; ≥1.
- `WORD_W`, 32, input word width.
- `prog_clk  in  1`  programming clock; everything is on its rising edge.
- `prog_reset_n  in  1`  synchronous, active-low reset.
- `start  in  1`  begin a load; sampled only in IDLE.
- `s_data  in  WORD_W`  bitstream word.
- `s_valid  in  1`  word valid.
- `s_ready  out  1`  word accepted when `s_valid && s_ready`.
- `ccff_head  out  NUM_CHAINS`  serial data into chain heads (bit i → chain i).
- `ccff_en  out  1`  chain shift enable; chains capture `ccff_head` at the edge ending a cycle with `ccff_en`=1.
- `ccff_tail  in  NUM_CHAINS`  chain tail outputs.
- `busy  out  1`  high while not IDLE.
- `done  out  1`  one-cycle completion pulse.
- `config_done  out  1`  level; the fabric holds valid configuration.
- `tail_parity  out  NUM_CHAINS`  running XOR of each chain's tail bits sampled during the load.

## Operation
- Derived values:
  - S = `WORD_W/NUM_CHAINS` slices per word.
  - W = ceil(`CHAIN_LEN*NUM_CHAINS/WORD_W`) words per load.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE: `start`=1 → LOAD. On the same edge: clear `config_done` and `tail_parity`, set shift counter to `CHAIN_LEN` and word counter to W.
- LOAD:
  - One-word buffer plus slice index.
  - When the buffer is valid, each cycle registers `ccff_head` ← buffer bits [(j+1)·N-1 : j·N] for slice j, sets `ccff_en` ← 1, increments j and decrements the shift counter.
  - Slice 0 is bits [N-1:0], so word bit 0 goes to chain 0 first.
  - The first bit shifted into a chain ends nearest its tail.
- `s_ready` = LOAD && words remaining > 0 && (buffer empty || the current slice is the last slice of the word or the last shift of the load). Back-to-back words therefore shift with no bubble.
- When the shift counter reaches 0, the remaining buffer bits are discarded (padding in the last word) and the state moves to FLUSH. Excess words are never accepted.
- If the buffer is empty in LOAD, `ccff_en` ← 0 and the chains hold (stall). There is no timeout.
- FLUSH: one cycle; `ccff_en` ← 0. Then → DONE.
- DONE: `done`=1, `config_done` ← 1, → IDLE. `config_done` stays high until the next `start`.
- Tail sampling: in every cycle with `ccff_en`=1, `tail_parity` ← `tail_parity ^ ccff_tail`.
- `start` outside IDLE is ignored.
- Reset, including mid-load: state IDLE, buffer empty, counters 0, and every output 0 (`s_ready`, `ccff_head`, `ccff_en`, `busy`, `done`, `config_done`, `tail_parity`). The chain content is undefined afterward; software must reload.

## Timing
- All outputs are registered except `s_ready`, which is combinational from state, counters and buffer status only, never from `s_valid`.
- A word accepted at edge k drives its first `ccff_en`/`ccff_head` in the cycle after edge k+1. Slice j appears in cycle k+1+j.
- With `s_valid` held high, `ccff_en` is high for exactly `CHAIN_LEN` consecutive cycles.
- Load latency: `start` edge → `done` = `CHAIN_LEN` + 4 cycles, with no stalls and the first word present at `start`.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- `tail_parity` is final when `done`=1.

## Structure
- The shared package `ccff_pkg` holds:
  - the state encoding constants (IDLE=0, LOAD=1, FLUSH=2, DONE=3);
  - the width function (clog2) used for the shift counter (clog2(`CHAIN_LEN`+1)) and the word counter.
- One sub-module, `ccff_word_serializer`. It holds the one-word buffer and slice index and presents an N-bit slice with valid / take / last-slice. The top holds the FSM, counters, tail parity and output registers.

## Test plan
All scenarios use `NUM_CHAINS`=4, `CHAIN_LEN`=8, `WORD_W`=8, so S=2 and W=4.
- Continuous stream of words 0x10, 0x32, 0x54, 0x76 after `start`:
  - `ccff_head` sequence is 0,1,2,3,4,5,6,7 on 8 consecutive `ccff_en` cycles;
  - `done` arrives 12 cycles after `start`;
  - `config_done`=1.
- Same data with `s_valid` dropped for 3 cycles after word 2: `ccff_en` gaps for exactly 3 cycles, 8 total shifts, and the head sequence is unchanged.
- `CHAIN_LEN`=7 build, same words: only 7 shifts (last head 6), 0x76 upper slice discarded, `s_ready` never high after the 4th word.
- Chain model preloaded with tails 0xF, 0x0, 0xF, 0x0, … over the 8 shifts: `tail_parity`=0x0 at `done`. With a single 0x1 tail bit overall: `tail_parity`=0x1.
- `prog_reset_n` low for 1 cycle after 3 shifts: all outputs are 0 next cycle and the state is IDLE. A new `start` then performs a full 8-shift load.
- `start` pulsed during LOAD: ignored, with no counter reload; `done` occurs exactly once.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

  // Loader FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ccff_state_e;

  // Ceiling log2 with a floor of 1 bit, used to size counters and indices.
  function automatic int unsigned ccff_clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// Bitstream word stream: valid/ready handshake from source to loader.
interface ccff_loader_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// One-word buffer that presents its contents as consecutive NUM_CHAINS-bit slices.
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned NUM_CHAINS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WORD_W-1:0]     load_data,
  input  logic                  take,
  output logic [NUM_CHAINS-1:0] slice_c,
  output logic                  valid_c,
  output logic                  last_c
);

  localparam int unsigned SLICES = WORD_W / NUM_CHAINS;
  localparam int unsigned IDX_W  = ccff_clog2(SLICES);

  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SLICES-1:0][NUM_CHAINS-1:0] slices_c;

  assign slices_c = word_q;
  assign slice_c  = slices_c[idx_q];
  assign valid_c  = valid_q;
  assign last_c   = (idx_q == IDX_W'(SLICES - 1));

  // Buffer update: a new word always restarts at slice 0; taking the last slice empties it.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (clear) begin
      valid_d = 1'b0;
      idx_d   = '0;
    end else if (load) begin
      word_d  = load_data;
      valid_d = 1'b1;
      idx_d   = '0;
    end else if (take && valid_q) begin
      if (last_c) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Serializes a bitstream word stream into parallel configuration flip-flop chains.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int unsigned NUM_CHAINS = 4,
  parameter int unsigned CHAIN_LEN  = 1024,
  parameter int unsigned WORD_W     = 32
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  input  logic                  start,
  ccff_loader_if.slave          s_if,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  ccff_en,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  config_done,
  output logic [NUM_CHAINS-1:0] tail_parity
);

  localparam int unsigned WORDS = (CHAIN_LEN * NUM_CHAINS + WORD_W - 1) / WORD_W;
  localparam int unsigned SC_W  = ccff_clog2(CHAIN_LEN + 1);
  localparam int unsigned WC_W  = ccff_clog2(WORDS + 1);

  ccff_state_e           state_q, state_d;
  logic [SC_W-1:0]       shift_cnt_q, shift_cnt_d;
  logic [WC_W-1:0]       word_cnt_q, word_cnt_d;
  logic [NUM_CHAINS-1:0] head_q, head_d;
  logic                  en_q, en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cfg_q, cfg_d;
  logic [NUM_CHAINS-1:0] par_q, par_d;

  logic [NUM_CHAINS-1:0] slice_c;
  logic                  buf_valid_c, last_slice_c;
  logic                  s_ready_c, accept_c, take_c, clear_c;

  // Handshake and buffer control; ready never looks at s_valid.
  always_comb begin
    s_ready_c = (state_q == ST_LOAD) && (word_cnt_q != '0) && (shift_cnt_q != '0) &&
                (!buf_valid_c || last_slice_c || (shift_cnt_q == SC_W'(1)));
    accept_c  = s_ready_c && s_if.s_valid;
    take_c    = (state_q == ST_LOAD) && buf_valid_c && (shift_cnt_q != '0);
    clear_c   = (state_q != ST_LOAD);
  end

  assign s_if.s_ready = s_ready_c;

  ccff_word_serializer #(
    .WORD_W     (WORD_W),
    .NUM_CHAINS (NUM_CHAINS)
  ) u_ser (
    .clk       (prog_clk),
    .rst_n     (prog_reset_n),
    .clear     (clear_c),
    .load      (accept_c),
    .load_data (s_if.s_data),
    .take      (take_c),
    .slice_c   (slice_c),
    .valid_c   (buf_valid_c),
    .last_c    (last_slice_c)
  );

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    word_cnt_d  = word_cnt_q;
    head_d      = head_q;
    en_d        = 1'b0;
    busy_d      = (state_q != ST_IDLE);
    done_d      = 1'b0;
    cfg_d       = cfg_q;
    par_d       = en_q ? (par_q ^ ccff_tail) : par_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          cfg_d       = 1'b0;
          par_d       = '0;
          shift_cnt_d = SC_W'(CHAIN_LEN);
          word_cnt_d  = WC_W'(WORDS);
        end
      end
      ST_LOAD: begin
        if (accept_c) word_cnt_d = word_cnt_q - WC_W'(1);
        if (shift_cnt_q == '0) begin
          state_d = ST_FLUSH;
        end else if (buf_valid_c) begin
          head_d      = slice_c;
          en_d        = 1'b1;
          shift_cnt_d = shift_cnt_q - SC_W'(1);
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE: begin
        done_d  = 1'b1;
        cfg_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q     <= ST_IDLE;
      shift_cnt_q <= '0;
      word_cnt_q  <= '0;
      head_q      <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_q       <= 1'b0;
      par_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      word_cnt_q  <= word_cnt_d;
      head_q      <= head_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_q       <= cfg_d;
      par_q       <= par_d;
    end
  end

  assign ccff_head   = head_q;
  assign ccff_en     = en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign config_done = cfg_q;
  assign tail_parity = par_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: 8-long and 7-long chain builds with a scoreboard of head slices.
module tb_ccff_loader;

  localparam int unsigned N  = 4;
  localparam int unsigned WW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, tb_start, tb_valid, sel7, pre_ld;
  logic [WW-1:0] tb_data;
  logic          start8, start7;
  logic [N-1:0]  head8, tail8, par8, head7, tail7, par7;
  logic          en8, busy8, done8, cfg8, en7, busy7, done7, cfg7;
  logic [N-1:0]  pre   [8];
  logic [N-1:0]  chain [8];
  logic [WW-1:0] words [4] = '{8'h10, 8'h32, 8'h54, 8'h76};
  logic [N-1:0]  q [$];
  int            n_vec = 0;
  int            n_mis = 0;

  logic          obs_ready, obs_en, obs_busy, obs_done, obs_cfg;
  logic [N-1:0]  obs_head, obs_par;

  ccff_loader_if #(.WORD_W(WW)) if8 ();
  ccff_loader_if #(.WORD_W(WW)) if7 ();

  assign if8.s_data  = tb_data;
  assign if8.s_valid = tb_valid;
  assign if7.s_data  = tb_data;
  assign if7.s_valid = tb_valid;
  assign start8      = tb_start & ~sel7;
  assign start7      = tb_start & sel7;
  assign tail7       = '0;

  ccff_loader #(.NUM_CHAINS(N), .CHAIN_LEN(8), .WORD_W(WW)) dut8 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start8), .s_if(if8),
    .ccff_head(head8), .ccff_en(en8), .ccff_tail(tail8), .busy(busy8),
    .done(done8), .config_done(cfg8), .tail_parity(par8)
  );

  ccff_loader #(.NUM_CHAINS(N), .CHAIN_LEN(7), .WORD_W(WW)) dut7 (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start7), .s_if(if7),
    .ccff_head(head7), .ccff_en(en7), .ccff_tail(tail7), .busy(busy7),
    .done(done7), .config_done(cfg7), .tail_parity(par7)
  );

  // Chain model for the 8-long build: stage 0 at the head, stage 7 drives the tail.
  always @(posedge clk) begin
    if (pre_ld) begin
      for (int i = 0; i < 8; i++) chain[i] <= pre[i];
    end else if (en8 === 1'b1) begin
      chain[0] <= head8;
      for (int i = 1; i < 8; i++) chain[i] <= chain[i-1];
    end
  end
  assign tail8 = chain[7];

  // Observe whichever build is under test.
  always_comb begin
    obs_ready = sel7 ? if7.s_ready : if8.s_ready;
    obs_en    = sel7 ? en7   : en8;
    obs_head  = sel7 ? head7 : head8;
    obs_busy  = sel7 ? busy7 : busy8;
    obs_done  = sel7 ? done7 : done8;
    obs_cfg   = sel7 ? cfg7  : cfg8;
    obs_par   = sel7 ? par7  : par8;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"},     32'(obs_ready), 32'd0);
    chk({tag, "_ccff_head"},   32'(obs_head),  32'd0);
    chk({tag, "_ccff_en"},     32'(obs_en),    32'd0);
    chk({tag, "_busy"},        32'(obs_busy),  32'd0);
    chk({tag, "_done"},        32'(obs_done),  32'd0);
    chk({tag, "_config_done"}, 32'(obs_cfg),   32'd0);
    chk({tag, "_tail_parity"}, 32'(obs_par),   32'd0);
  endtask

  task automatic preload_chain();
    @(negedge clk);
    pre_ld = 1'b1;
    @(negedge clk);
    pre_ld = 1'b0;
  endtask

  // One load: stall_n ready cycles withheld after word 2, optional start pulse at cycle mid_at,
  // optional reset once abort_at shifts have been seen.
  task automatic run_load(input bit use7, input int stall_n, input int mid_at,
                          input int abort_at, input logic [N-1:0] exp_par);
    int cl, widx, pushed, shifts, gaps, stalls_left, done_cnt, done_cyc, rise, fall, late;
    bit acc;
    logic [N-1:0] eh;
    cl = use7 ? 7 : 8;
    sel7 = use7;
    q.delete();
    widx = 0; pushed = 0; shifts = 0; gaps = 0; stalls_left = stall_n;
    done_cnt = 0; done_cyc = -1; rise = -1; fall = -1; late = 0;
    @(negedge clk);
    chk("idle_ready", 32'(obs_ready), 32'd0);
    tb_start = 1'b1;
    tb_valid = 1'b1;
    tb_data  = words[0];
    acc      = 1'b0;
    for (int m = 0; m < 30; m++) begin
      @(negedge clk);
      tb_start = (m == mid_at);
      if (acc) widx++;
      if (obs_en) begin
        shifts++;
        if (q.size() > 0) eh = q.pop_front();
        else eh = 'x;
        chk($sformatf("head_shift%0d", shifts), 32'(obs_head), 32'(eh));
      end else if (shifts > 0 && shifts < cl) begin
        gaps++;
      end
      if (abort_at > 0 && shifts == abort_at) begin
        rst_n    = 1'b0;
        tb_valid = 1'b0;
        @(negedge clk);
        check_zero("midload_reset");
        rst_n = 1'b1;
        q.delete();
        return;
      end
      if (obs_done) begin
        if (done_cnt == 0) begin
          done_cyc = m;
          chk("parity_at_done", 32'(obs_par), 32'(exp_par));
          chk("config_done_at_done", 32'(obs_cfg), 32'd1);
        end
        done_cnt++;
      end
      if (obs_busy && rise < 0) rise = m;
      if (!obs_busy && rise >= 0 && fall < 0) fall = m;
      tb_valid = (widx < 4);
      if (tb_valid && stalls_left > 0 && widx == 2 && obs_ready) begin
        tb_valid = 1'b0;
        stalls_left--;
      end
      tb_data = words[(widx < 4) ? widx : 3];
      if (obs_ready && widx >= 4) late++;
      acc = tb_valid && obs_ready;
      if (acc) begin
        for (int s = 0; s < 2; s++) begin
          if (pushed < cl) begin
            q.push_back(tb_data[s*4 +: 4]);
            pushed++;
          end
        end
      end
    end
    chk("done_count",   32'(done_cnt), 32'd1);
    chk("done_latency", 32'(done_cyc), 32'(cl + 4 + stall_n));
    chk("shift_count",  32'(shifts),   32'(cl));
    chk("en_gap",       32'(gaps),     32'(stall_n));
    chk("sb_leftover",  32'(q.size()), 32'd0);
    chk("late_ready",   32'(late),     32'd0);
    chk("words_taken",  32'(widx),     32'd4);
    chk("busy_rise",    32'(rise),     32'd1);
    chk("busy_fall",    32'(fall),     32'(done_cyc + 1));
    chk("config_level", 32'(obs_cfg),  32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    tb_start = 1'b0;
    tb_valid = 1'b0;
    tb_data  = '0;
    sel7     = 1'b0;
    pre_ld   = 1'b0;
    for (int i = 0; i < 8; i++) pre[i] = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    chk("reset_s_ready_b7", 32'(if7.s_ready), 32'd0);
    chk("reset_en_b7",      32'(en7),         32'd0);
    rst_n = 1'b1;

    // Tails alternate 0xF, 0x0 over the load.
    for (int i = 0; i < 8; i++) pre[i] = (i % 2 == 1) ? 4'hF : 4'h0;
    preload_chain();
    run_load(1'b0, 0, -1, -1, 4'h0);

    // Single set tail bit; also withhold three ready cycles after word 2.
    for (int i = 0; i < 8; i++) pre[i] = '0;
    pre[3] = 4'h1;
    preload_chain();
    run_load(1'b0, 3, -1, -1, 4'h1);

    // Reset after three shifts, then a full load from IDLE.
    run_load(1'b0, 0, -1, 3, 4'h0);
    run_load(1'b0, 0, -1, -1, 4'h0);

    // Start pulsed in the middle of a load.
    run_load(1'b0, 0, 5, -1, 4'h0);

    // Seven-long chains: upper slice of the last word is padding.
    run_load(1'b1, 0, -1, -1, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
